// File: rtl/dehaze_pkg.sv
// dehaze_pkg
// Shared definitions for the dehaze pipeline stages: pixel width, default
// coordinate counter widths and the frame-tracking state encoding used by
// consumers of the dark-channel stream.
package dehaze_pkg;

  localparam int DATA_W = 8;
  localparam int DEF_XW = 10;
  localparam int DEF_YW = 10;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    DONE
  } state_e;

endpackage

// File: rtl/stream_pos_counter.sv
// stream_pos_counter
// Tracks position inside a vsync/href/clken video stream. Registers vsync and
// href to produce frame/line edge strobes, and keeps saturating x/y counters
// giving the coordinate of the pixel presented in the current cycle.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   vsync       frame valid
//   href        line valid
//   clken       pixel strobe
//   clear       restart the counters at (0,0) this cycle (frame start)
//   count_en    advance counters on consumed pixels / line ends
//   rise, fall  vsync edges (current input vs registered copy)
//   href_fall   end of line
//   pix_valid   a pixel is consumed this cycle (vsync & href & clken)
//   x_cur/y_cur coordinate of the pixel presented this cycle
module stream_pos_counter #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  input  logic          clear,
  input  logic          count_en,
  output logic          rise,
  output logic          fall,
  output logic          href_fall,
  output logic          pix_valid,
  output logic [XW-1:0] x_cur,
  output logic [YW-1:0] y_cur
);

  logic          vsync_prev_q;
  logic          href_prev_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // The registered vsync resets high so a frame already running when reset
  // releases never looks like a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= 1'b1;
      href_prev_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      vsync_prev_q <= vsync;
      href_prev_q  <= href;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  always_comb begin
    rise      = vsync & ~vsync_prev_q;
    fall      = ~vsync & vsync_prev_q;
    href_fall = ~href & href_prev_q;
    pix_valid = vsync & href & clken;

    // A pixel arriving together with the frame start sits at (0,0).
    x_cur = clear ? '0 : x_q;
    y_cur = clear ? '0 : y_q;

    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
      if (pix_valid) begin
        x_d = XW'(1);
      end
    end else if (count_en) begin
      // Counters stick at all-ones instead of wrapping on oversized frames.
      if (pix_valid && (x_q != '1)) begin
        x_d = x_q + XW'(1);
      end
      if (href_fall) begin
        x_d = '0;
        if (y_q != '1) begin
          y_d = y_q + YW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/atmo_light_estimator.sv
// atmo_light_estimator
// Consumes the dark-channel stream and, per frame, finds the brightest dark
// value (atmospheric light A) and the coordinate of its first occurrence.
// The result is published with a one-cycle atmo_valid pulse at frame end and
// held until the next frame completes.
//
// Build option: define ATMO_SMOOTH_EN to low-pass the published value across
// frames as (3*prev + new + 2) >> 2; the first frame after reset is loaded
// unfiltered. Coordinates are always those of the current frame.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   dark_vsync   frame valid
//   dark_href    line valid
//   dark_clken   pixel strobe (pixel consumed when href & clken)
//   dark_value   dark-channel pixel value
//   atmo_valid   one-cycle pulse, result updated
//   atmo_value   estimated atmospheric light A
//   atmo_x/y     0-based coordinate of the maximum
//   busy         a frame is being accumulated
module atmo_light_estimator
  import dehaze_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = DEF_XW,
  parameter int YW    = DEF_YW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dark_vsync,
  input  logic              dark_href,
  input  logic              dark_clken,
  input  logic [DATA_W-1:0] dark_value,
  output logic              atmo_valid,
  output logic [DATA_W-1:0] atmo_value,
  output logic [XW-1:0]     atmo_x,
  output logic [YW-1:0]     atmo_y,
  output logic              busy
);

  // Oversized frames still work, but coordinates beyond the counter range
  // collapse onto the saturated value.
  if ((IMG_W > (1 << XW)) || (IMG_H > (1 << YW))) begin : g_dim_check
    $warning("atmo_light_estimator: image larger than coordinate counters");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [XW-1:0]     best_x_q, best_x_d;
  logic [YW-1:0]     best_y_q, best_y_d;
  logic              atmo_valid_q, atmo_valid_d;
  logic [DATA_W-1:0] atmo_value_q, atmo_value_d;
  logic [XW-1:0]     atmo_x_q, atmo_x_d;
  logic [YW-1:0]     atmo_y_q, atmo_y_d;

  logic              rise, fall, href_fall, pix_valid;
  logic              clear, count_en;
  logic [XW-1:0]     x_cur;
  logic [YW-1:0]     y_cur;
  logic [DATA_W-1:0] cand_max;
  logic [XW-1:0]     cand_x;
  logic [YW-1:0]     cand_y;
  logic [DATA_W-1:0] new_value;

  stream_pos_counter #(
    .XW(XW),
    .YW(YW)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .vsync    (dark_vsync),
    .href     (dark_href),
    .clken    (dark_clken),
    .clear    (clear),
    .count_en (count_en),
    .rise     (rise),
    .fall     (fall),
    .href_fall(href_fall),
    .pix_valid(pix_valid),
    .x_cur    (x_cur),
    .y_cur    (y_cur)
  );

  // A frame starts from ARMED, or straight out of DONE when the gap between
  // frames is a single low vsync cycle.
  assign clear    = rise & ((state_q == ARMED) | (state_q == DONE));
  assign count_en = (state_q == ACTIVE);

`ifdef ATMO_SMOOTH_EN
  logic       first_q, first_d;
  logic [9:0] blend_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
    end else begin
      first_q <= first_d;
    end
  end

  // 3*prev + new + 2 peaks at 1022, so 10 bits never overflow.
  always_comb begin
    blend_sum = {2'b00, atmo_value_q} + {1'b0, atmo_value_q, 1'b0}
              + {2'b00, max_q} + 10'd2;
    new_value = first_q ? max_q : DATA_W'(blend_sum >> 2);
    first_d   = first_q;
    if ((state_q == ACTIVE) && fall) begin
      first_d = 1'b0;
    end
  end
`else
  assign new_value = max_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      max_q        <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      atmo_valid_q <= 1'b0;
      atmo_value_q <= '0;
      atmo_x_q     <= '0;
      atmo_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      max_q        <= max_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      atmo_valid_q <= atmo_valid_d;
      atmo_value_q <= atmo_value_d;
      atmo_x_q     <= atmo_x_d;
      atmo_y_q     <= atmo_y_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    atmo_valid_d = 1'b0;
    atmo_value_d = atmo_value_q;
    atmo_x_d     = atmo_x_q;
    atmo_y_d     = atmo_y_q;

    // On the start cycle the comparison runs against a cleared maximum, so a
    // pixel arriving with the rise is the first candidate.
    cand_max = clear ? '0 : max_q;
    cand_x   = clear ? '0 : best_x_q;
    cand_y   = clear ? '0 : best_y_q;

    unique case (state_q)
      IDLE: begin
        if (!dark_vsync) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (fall) begin
          state_d      = DONE;
          atmo_valid_d = 1'b1;
          atmo_value_d = new_value;
          atmo_x_d     = best_x_q;
          atmo_y_d     = best_y_q;
        end
      end
      DONE: begin
        state_d = rise ? ACTIVE : ARMED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strict compare keeps the first occurrence on ties.
    if (clear || count_en) begin
      max_d    = cand_max;
      best_x_d = cand_x;
      best_y_d = cand_y;
      if (pix_valid && (dark_value > cand_max)) begin
        max_d    = dark_value;
        best_x_d = x_cur;
        best_y_d = y_cur;
      end
    end
  end

  assign atmo_valid = atmo_valid_q;
  assign atmo_value = atmo_value_q;
  assign atmo_x     = atmo_x_q;
  assign atmo_y     = atmo_y_q;
  assign busy       = (state_q == ACTIVE);

endmodule
